// File: rtl/din_sequencer.sv
// ---------------------------------------------------------------------------------------------
// din_sequencer
//
// Supply-side driver for the multicycle processor. Holds a small program image and feeds it to
// the processor one word at a time: each instruction word goes out on DIN with a one-cycle Run
// pulse. An mvi instruction has its immediate word presented on DIN and held there until Done.
// The sequencer then advances on Done.
//
// Parameters
//   ADDR_W   program buffer address width (depth = 2**ADDR_W 16-bit words)
//   MVI_OP   opcode value in DIN[8:6] that consumes a following immediate word
//   TIMEOUT  maximum cycles spent waiting for Done (watchdog builds only), must be >= 1
//
// Build option
//   TIMEOUT_EN  when defined, adds a watchdog on the Done wait. It raises a sticky Timeout and
//               abandons the program. Without it, Timeout is tied low and the wait is unbounded.
//
// Ports
//   Clock     in   system clock, all state updates on posedge
//   Reset     in   synchronous active-high reset, clears every output (not the buffer)
//   Load      in   write LoadData to buffer[LoadAddr], only while Busy=0
//   LoadAddr  in   buffer write address
//   LoadData  in   buffer write data
//   Start     in   begin a program, only while idle
//   ProgLen   in   number of words to execute (0..2**ADDR_W), latched on Start
//   DIN       out  registered word presented to the processor
//   Run       out  registered processor Run, one cycle per instruction
//   Done      in   processor Done, sampled only while waiting on an instruction
//   Busy      out  high from an accepted Start until the sequencer is idle again
//   PC        out  index of the word currently being issued
//   Finished  out  one-cycle pulse when the program completes
//   Timeout   out  sticky watchdog flag
// ---------------------------------------------------------------------------------------------
module din_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter logic [2:0]  MVI_OP  = 3'b001,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [15:0]       LoadData,
  input  logic              Start,
  input  logic [ADDR_W:0]   ProgLen,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic              Finished,
  output logic              Timeout
);

  localparam int unsigned     Depth  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PcOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] PcTwo  = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W:0] MaxLen = (ADDR_W + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StImm,
    StWait,
    StFin
  } state_e;

  state_e            state_q;
  logic [15:0]       mem_q [Depth];
  logic [15:0]       din_q;
  logic              run_q;
  logic              busy_q;
  logic              finished_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W:0]   len_q;
  logic              timeout_q;

  // Program counter arithmetic is done one bit wider so that stepping past the last word of a
  // full buffer is seen as "done" instead of wrapping back to index 0.
  logic [ADDR_W:0]   pc_ext;
  logic [ADDR_W:0]   pc_plus1;
  logic [ADDR_W:0]   pc_plus2;
  logic [ADDR_W:0]   pc_done;
  logic [ADDR_W:0]   start_len;
  logic              is_mvi;
  logic              imm_present;

  always_comb begin
    pc_ext      = {1'b0, pc_q};
    pc_plus1    = pc_ext + PcOne;
    pc_plus2    = pc_ext + PcTwo;
    pc_done     = (state_q == StImm) ? pc_plus2 : pc_plus1;
    // Lengths beyond the buffer depth are clamped so PC can never leave the buffer.
    start_len   = (ProgLen > MaxLen) ? MaxLen : ProgLen;
    is_mvi      = (din_q[8:6] == MVI_OP);
    imm_present = (pc_plus1 < len_q);
  end

  // Program buffer: no reset, contents survive Reset.
  always_ff @(posedge Clock) begin
    if (!Reset && Load && !busy_q) begin
      mem_q[LoadAddr] <= LoadData;
    end
  end

`ifdef TIMEOUT_EN
  localparam int unsigned   CntW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      din_q      <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      pc_q       <= '0;
      len_q      <= '0;
      timeout_q  <= 1'b0;
`ifdef TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      finished_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            len_q     <= start_len;
            pc_q      <= '0;
            timeout_q <= 1'b0;
            if (start_len == '0) begin
              // Empty program: report completion without ever becoming busy.
              finished_q <= 1'b1;
              state_q    <= StFin;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StFetch;
            end
          end
        end

        StFetch: begin
          din_q   <= mem_q[pc_q];
          run_q   <= 1'b1;
          state_q <= StIssue;
        end

        StIssue: begin
          run_q <= 1'b0;
`ifdef TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (is_mvi) begin
            // An mvi at the end of the program has no immediate; present zero instead.
            din_q   <= imm_present ? mem_q[pc_plus1[ADDR_W-1:0]] : 16'h0000;
            state_q <= StImm;
          end else begin
            state_q <= StWait;
          end
        end

        StImm, StWait: begin
          if (Done) begin
            if (pc_done >= len_q) begin
              finished_q <= 1'b1;
              state_q    <= StFin;
            end else begin
              pc_q    <= pc_done[ADDR_W-1:0];
              state_q <= StFetch;
            end
          end
`ifdef TIMEOUT_EN
          else if (cnt_q == CntMax) begin
            // Abandon the program silently: no Finished pulse, just the sticky flag.
            timeout_q <= 1'b1;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
`endif
        end

        StFin: begin
          busy_q  <= 1'b0;
          run_q   <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign PC       = pc_q;
  assign Finished = finished_q;
`ifdef TIMEOUT_EN
  assign Timeout  = timeout_q;
`else
  assign Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_din_sequencer.sv
// Bench for din_sequencer: a negedge monitor pops expected Run/Finished events from a
// scoreboard queue filled by each scenario task before it drives stimulus.
module tb_din_sequencer;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          Reset;
  logic          Load;
  logic [AW-1:0] LoadAddr;
  logic [15:0]   LoadData;
  logic          Start;
  logic [AW:0]   ProgLen;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;
  logic          Busy;
  logic [AW-1:0] PC;
  logic          Finished;
  logic          Timeout;

  din_sequencer #(
    .ADDR_W (AW),
    .MVI_OP (3'b001),
    .TIMEOUT(8)
  ) dut (
    .Clock   (clk),
    .Reset   (Reset),
    .Load    (Load),
    .LoadAddr(LoadAddr),
    .LoadData(LoadData),
    .Start   (Start),
    .ProgLen (ProgLen),
    .DIN     (DIN),
    .Run     (Run),
    .Done    (Done),
    .Busy    (Busy),
    .PC      (PC),
    .Finished(Finished),
    .Timeout (Timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_fin;
    logic [15:0]   din;
    logic [AW-1:0] pc;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev_mon;
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Scoreboard monitor: every Run or Finished pulse must match the next expected event.
  always @(negedge clk) begin
    if (Reset === 1'b0) begin
      if (Run === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL run_event: unexpected Run DIN=%h PC=%0d, none expected", DIN, PC);
        end else begin
          ev_mon = exp_q.pop_front();
          if (ev_mon.is_fin || DIN !== ev_mon.din || PC !== ev_mon.pc) begin
            n_fail++;
            $display("FAIL run_event: got Run DIN=%h PC=%0d, want fin=%0b DIN=%h PC=%0d",
                     DIN, PC, ev_mon.is_fin, ev_mon.din, ev_mon.pc);
          end
        end
      end
      if (Finished === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fin_event: unexpected Finished, none expected");
        end else begin
          ev_mon = exp_q.pop_front();
          if (!ev_mon.is_fin) begin
            n_fail++;
            $display("FAIL fin_event: got Finished, want Run DIN=%h PC=%0d",
                     ev_mon.din, ev_mon.pc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [15:0] w, input logic [AW-1:0] p);
    ev_t e;
    e.is_fin = 1'b0;
    e.din    = w;
    e.pc     = p;
    exp_q.push_back(e);
  endtask

  task automatic push_fin();
    ev_t e;
    e.is_fin = 1'b1;
    e.din    = '0;
    e.pc     = '0;
    exp_q.push_back(e);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    Load     = 1'b1;
    LoadAddr = a;
    LoadData = d;
    step();
    Load     = 1'b0;
  endtask

  task automatic start_prog(input logic [AW:0] len);
    Start   = 1'b1;
    ProgLen = len;
    step();
    Start   = 1'b0;
  endtask

  // Bounded wait for a Run pulse; returns at the negedge where Run is high.
  task automatic wait_run(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Run === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    Done = 1'b1;
    step();
    Done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    n_cmp += 6;
    if (DIN !== 16'h0000) begin n_fail++; $display("FAIL reset_din: got %h want 0000", DIN); end
    if (Run !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b want 0", Run); end
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    if (PC !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", PC); end
    if (Finished !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %b want 0", Finished); end
    if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", Timeout); end
    Reset = 1'b0;
    step();
  endtask

  // T1 plus Load/Start ignored while busy.
  task automatic test_mv();
    bit seen;
    load_word(0, 16'h0001);
    load_word(1, 16'h0002);
    push_run(16'h0001, 0);
    push_run(16'h0002, 1);
    push_fin();
    start_prog(2);
    n_cmp++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL mv_busy_rise: got %b want 1", Busy); end
    wait_run(seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL mv_run1: no Run within 20 cycles, want one"); end
    step();
    // Busy: these must be ignored.
    Load = 1'b1; LoadAddr = 1; LoadData = 16'hBEEF; Start = 1'b1; ProgLen = 0;
    step();
    Load = 1'b0; Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (DIN !== 16'h0001 || Run !== 1'b0 || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mv_wait_hold: got DIN=%h Run=%b Busy=%b want 0001/0/1", DIN, Run, Busy);
      end
      step();
    end
    pulse_done();
    wait_run(seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL mv_run2: no Run within 20 cycles, want one"); end
    step();
    pulse_done();
    n_cmp++;
    if (Finished !== 1'b1) begin n_fail++; $display("FAIL mv_fin: got %b want 1", Finished); end
    step();
    n_cmp++;
    if (Busy !== 1'b0 || Finished !== 1'b0) begin
      n_fail++;
      $display("FAIL mv_busy_fall: got Busy=%b Fin=%b want 0/0", Busy, Finished);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL mv_events: %0d events left, want 0", exp_q.size());
    end
  endtask

  // T2 and T5 share shape: one mvi, immediate or the missing-immediate zero.
  task automatic test_mvi(input logic [AW:0] len, input logic [15:0] imm, input string nm);
    bit seen;
    load_word(0, 16'h0040);
    load_word(1, 16'h0005);
    push_run(16'h0040, 0);
    push_fin();
    start_prog(len);
    wait_run(seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL %s_run: no Run within 20 cycles", nm); end
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (DIN !== imm || Run !== 1'b0 || PC !== '0) begin
        n_fail++;
        $display("FAIL %s_imm: got DIN=%h Run=%b PC=%0d want %h/0/0", nm, DIN, Run, PC, imm);
      end
      step();
    end
    pulse_done();
    n_cmp++;
    if (Finished !== 1'b1 || DIN !== imm) begin
      n_fail++;
      $display("FAIL %s_fin: got Fin=%b DIN=%h want 1/%h", nm, Finished, DIN, imm);
    end
    step();
    n_cmp++;
    if (Busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_end: got Busy=%b left=%0d want 0/0", nm, Busy, exp_q.size());
    end
  endtask

  // T3: empty program.
  task automatic test_zero_len();
    push_fin();
    start_prog(0);
    n_cmp++;
    if (Finished !== 1'b1 || Busy !== 1'b0 || Run !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_fin: got Fin=%b Busy=%b Run=%b want 1/0/0", Finished, Busy, Run);
    end
    step();
    n_cmp++;
    if (Finished !== 1'b0 || Busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_after: got Fin=%b Busy=%b left=%0d want 0/0/0",
               Finished, Busy, exp_q.size());
    end
  endtask

  // T4: reset during the Done wait.
  task automatic test_reset_mid();
    bit seen;
    load_word(0, 16'h0001);
    push_run(16'h0001, 0);
    start_prog(1);
    wait_run(seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL rmid_run: no Run within 20 cycles"); end
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_cmp++;
    if (DIN !== 16'h0000 || Run !== 1'b0 || Busy !== 1'b0 || PC !== '0) begin
      n_fail++;
      $display("FAIL rmid_outs: got DIN=%h Run=%b Busy=%b PC=%0d want 0/0/0/0",
               DIN, Run, Busy, PC);
    end
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (Finished !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_nofin: got Fin=%b Busy=%b want 0/0", Finished, Busy);
      end
      step();
    end
  endtask

  // Random programs walked by a reference model; len=16 exercises the full buffer.
  task automatic test_program(input int len);
    logic [15:0]   prog [16];
    logic [15:0]   words [$];
    logic [15:0]   imms [$];
    bit            mvis [$];
    int            idx;
    bit            seen;
    logic [15:0]   w;
    logic [15:0]   im;
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      w[8:6] = 3'($urandom_range(0, 3));
      prog[i] = w;
      load_word(AW'(i), w);
    end
    idx = 0;
    while (idx < len) begin
      w = prog[idx];
      push_run(w, AW'(idx));
      words.push_back(w);
      mvis.push_back(w[8:6] == 3'b001);
      imms.push_back((w[8:6] == 3'b001 && idx + 1 < len) ? prog[idx + 1] : 16'h0000);
      idx += (w[8:6] == 3'b001) ? 2 : 1;
    end
    push_fin();
    start_prog((AW + 1)'(len));
    for (int k = 0; k < words.size(); k++) begin
      wait_run(seen);
      n_cmp++;
      if (!seen) begin
        n_fail++;
        $display("FAIL prog_run: instr %0d no Run within 20 cycles", k);
        break;
      end
      step();
      repeat ($urandom_range(0, 3)) step();
      w = mvis[k] ? imms[k] : words[k];
      im = DIN;
      n_cmp++;
      if (im !== w || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL prog_din: instr %0d got DIN=%h Run=%b want %h/0", k, im, Run, w);
      end
      pulse_done();
    end
    step();
    n_cmp++;
    if (Busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL prog_end: len %0d got Busy=%b left=%0d want 0/0", len, Busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    bit seen;
    load_word(0, 16'h0001);
    push_run(16'h0001, 0);
    start_prog(1);
    wait_run(seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL tmo_run: no Run within 20 cycles"); end
    step();
`ifdef TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      n_cmp++;
      if (Timeout !== 1'b0 || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL tmo_early: cycle %0d got Tmo=%b Busy=%b want 0/1", i, Timeout, Busy);
      end
    end
    step();
    n_cmp++;
    if (Timeout !== 1'b1 || Busy !== 1'b0 || Run !== 1'b0 || Finished !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: got Tmo=%b Busy=%b Run=%b Fin=%b want 1/0/0/0",
               Timeout, Busy, Run, Finished);
    end
    step();
    step();
    n_cmp++;
    if (Timeout !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tmo_sticky: got Tmo=%b left=%0d want 1/0", Timeout, exp_q.size());
    end
    push_fin();
    start_prog(0);
    n_cmp++;
    if (Timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", Timeout); end
    step();
`else
    repeat (12) step();
    n_cmp++;
    if (Timeout !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_none: got Tmo=%b Busy=%b want 0/1", Timeout, Busy);
    end
    push_fin();
    pulse_done();
    step();
    n_cmp++;
    if (Busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tmo_none_end: got Busy=%b left=%0d want 0/0", Busy, exp_q.size());
    end
`endif
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; LoadAddr = '0; LoadData = '0;
    Start = 1'b0; ProgLen = '0; Done = 1'b0;
    test_reset();
    test_mv();
    test_mvi(2, 16'h0005, "mvi");
    test_zero_len();
    test_reset_mid();
    test_mvi(1, 16'h0000, "mvi_last");
    test_program(16);
    test_program(5);
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
